// File: rtl/vga_defs_pkg.sv
// Shared sprite/display definitions: table geometry, sprite entry layout and scan states.
package vga_defs;

  localparam int unsigned NUM_SPR   = 32;
  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SPR_SIZE  = 16;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned PAT_W     = 4;
  localparam int unsigned OFF_W     = 4;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [PAT_W-1:0] pattern;
    logic             vis;
  } sprite_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/sprite_slot_match.sv
// One scanline sprite slot: holds x/pattern/row of a selected sprite and
// tests whether the current pixel column falls inside it.
module sprite_slot_match
  import vga_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [X_W-1:0]   load_x,
  input  logic [PAT_W-1:0] load_pattern,
  input  logic [OFF_W-1:0] load_row,
  input  logic [X_W-1:0]   h_count,
  output logic             valid,
  output logic [PAT_W-1:0] pattern,
  output logic [OFF_W-1:0] row,
  output logic             hit_c,
  output logic [OFF_W-1:0] col_c
);

  logic [X_W-1:0] x;
  logic [X_W:0]   h_ext;
  logic [X_W:0]   lo;
  logic [X_W:0]   hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid   <= 1'b0;
      x       <= '0;
      pattern <= '0;
      row     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      x       <= load_x;
      pattern <= load_pattern;
      row     <= load_row;
    end
  end

  // One extra bit so sprites near the right edge clip instead of wrapping to column 0
  assign h_ext = {1'b0, h_count};
  assign lo    = {1'b0, x};
  assign hi    = lo + (X_W+1)'(SPR_SIZE);
  assign hit_c = valid && (h_ext >= lo) && (h_ext < hi);
  assign col_c = OFF_W'(h_count - x);

endmodule

// File: rtl/sprite_line_ctrl.sv
// Sprite attribute table, per-line sprite scan and per-pixel hit reporting.
// Optional overflow detection is compiled in with `define SPRITE_OVERFLOW_EN.
module sprite_line_ctrl
  import vga_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] sprite_sel,
  input  logic [X_W-1:0]   sprite_x,
  input  logic [Y_W-1:0]   sprite_y,
  input  logic             sprite_vis,
  input  logic             sprite_pos,
  input  logic             sprite_attr,
  input  logic             line_start,
  input  logic [Y_W-1:0]   next_line,
  input  logic [X_W-1:0]   h_count,
  output logic             spr_hit,
  output logic [PAT_W-1:0] spr_pattern,
  output logic [OFF_W-1:0] spr_row,
  output logic [OFF_W-1:0] spr_col,
  output logic             scan_busy,
  output logic             spr_overflow
);

  sprite_entry_t tbl [NUM_SPR];

  scan_state_t      state;
  scan_state_t      state_next;
  logic [IDX_W-1:0] idx;
  logic [Y_W-1:0]   line;

  sprite_entry_t    cur;
  logic [X_W-1:0]   dy;
  logic             scan_en;
  logic             match;

  logic [NUM_SLOTS-1:0] load_vec;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [NUM_SLOTS-1:0] slot_hit;
  logic [PAT_W-1:0]     slot_pattern [NUM_SLOTS];
  logic [OFF_W-1:0]     slot_row     [NUM_SLOTS];
  logic [OFF_W-1:0]     slot_col     [NUM_SLOTS];

  logic             win_hit;
  logic [PAT_W-1:0] win_pattern;
  logic [OFF_W-1:0] win_row;
  logic [OFF_W-1:0] win_col;

  // Attribute table; a write lands at the edge, so a same-cycle scan read sees the old entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      if (sprite_pos) begin
        tbl[sprite_sel].x <= sprite_x;
        tbl[sprite_sel].y <= sprite_y;
      end
      if (sprite_attr) begin
        tbl[sprite_sel].pattern <= sprite_x[PAT_W-1:0];
      end
      if (sprite_pos || sprite_attr) begin
        tbl[sprite_sel].vis <= sprite_vis;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (line_start) state_next = SCAN;
      SCAN: begin
        if (line_start) begin
          state_next = SCAN;
        end else if (idx == IDX_W'(NUM_SPR - 1)) begin
          state_next = DONE;
        end
      end
      DONE: if (line_start) state_next = SCAN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      line <= '0;
    end else if (line_start) begin
      idx  <= '0;
      line <= next_line;
    end else if (state == SCAN) begin
      idx <= idx + 1'b1;
    end
  end

  // A negative line-y sets the top bit, so the range test never wraps
  assign cur     = tbl[idx];
  assign dy      = {1'b0, line} - {1'b0, cur.y};
  assign scan_en = (state == SCAN) && !line_start;
  assign match   = scan_en && cur.vis && !dy[X_W-1] && (dy < X_W'(SPR_SIZE));

  always_comb begin
    logic taken;
    load_vec = '0;
    taken    = 1'b0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (!slot_valid[k] && !taken) begin
        load_vec[k] = match;
        taken       = 1'b1;
      end
    end
  end

`ifdef SPRITE_OVERFLOW_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spr_overflow <= 1'b0;
    end else if (line_start) begin
      spr_overflow <= 1'b0;
    end else if (match && (&slot_valid)) begin
      spr_overflow <= 1'b1;
    end
  end
`else
  assign spr_overflow = 1'b0;
`endif

  for (genvar k = 0; k < int'(NUM_SLOTS); k++) begin : g_slot
    sprite_slot_match u_slot (
      .clk          (clk),
      .reset        (reset),
      .clear        (line_start),
      .load         (load_vec[k]),
      .load_x       (cur.x),
      .load_pattern (cur.pattern),
      .load_row     (OFF_W'(dy)),
      .h_count      (h_count),
      .valid        (slot_valid[k]),
      .pattern      (slot_pattern[k]),
      .row          (slot_row[k]),
      .hit_c        (slot_hit[k]),
      .col_c        (slot_col[k])
    );
  end

  // Walk from the highest slot down so the lowest hitting slot ends up winning
  always_comb begin
    win_hit     = 1'b0;
    win_pattern = '0;
    win_row     = '0;
    win_col     = '0;
    for (int k = int'(NUM_SLOTS) - 1; k >= 0; k--) begin
      if (slot_hit[k]) begin
        win_hit     = 1'b1;
        win_pattern = slot_pattern[k];
        win_row     = slot_row[k];
        win_col     = slot_col[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_busy   <= 1'b0;
      spr_hit     <= 1'b0;
      spr_pattern <= '0;
      spr_row     <= '0;
      spr_col     <= '0;
    end else begin
      scan_busy <= (state_next == SCAN);
      if ((state == DONE) && win_hit) begin
        spr_hit     <= 1'b1;
        spr_pattern <= win_pattern;
        spr_row     <= win_row;
        spr_col     <= win_col;
      end else begin
        spr_hit     <= 1'b0;
        spr_pattern <= '0;
        spr_row     <= '0;
        spr_col     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_ctrl.sv
// Self-checking bench for sprite_line_ctrl against a list-based reference model.
module tb_sprite_line_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] sprite_sel = '0;
  logic [9:0] sprite_x = '0;
  logic [8:0] sprite_y = '0;
  logic       sprite_vis = 1'b0;
  logic       sprite_pos = 1'b0;
  logic       sprite_attr = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] next_line = '0;
  logic [9:0] h_count = '0;
  logic       spr_hit;
  logic [3:0] spr_pattern;
  logic [3:0] spr_row;
  logic [3:0] spr_col;
  logic       scan_busy;
  logic       spr_overflow;

  int n_cmp = 0;
  int n_err = 0;

  // reference table and the expected per-line sprite list
  int mx [32];
  int my [32];
  int mp [32];
  int mv [32];
  int sx [4];
  int sp [4];
  int sr [4];
  int sn;
  int sovf;

  sprite_line_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .sprite_sel   (sprite_sel),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_vis   (sprite_vis),
    .sprite_pos   (sprite_pos),
    .sprite_attr  (sprite_attr),
    .line_start   (line_start),
    .next_line    (next_line),
    .h_count      (h_count),
    .spr_hit      (spr_hit),
    .spr_pattern  (spr_pattern),
    .spr_row      (spr_row),
    .spr_col      (spr_col),
    .scan_busy    (scan_busy),
    .spr_overflow (spr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      mx[i] = 0; my[i] = 0; mp[i] = 0; mv[i] = 0;
    end
    sn = 0;
    sovf = 0;
  endtask

  task automatic write_spr(input int sel, input bit pos, input bit attr,
                           input int x, input int y, input int pat, input int vis);
    logic [9:0] xv;
    xv = (attr && !pos) ? 10'(pat) : 10'(x);
    sprite_sel  = 5'(sel);
    sprite_x    = xv;
    sprite_y    = 9'(y);
    sprite_vis  = vis[0];
    sprite_pos  = pos;
    sprite_attr = attr;
    if (pos) begin
      mx[sel] = int'(xv);
      my[sel] = y;
    end
    if (attr) mp[sel] = int'(xv) % 16;
    if (pos || attr) mv[sel] = vis % 2;
    tick();
    sprite_pos  = 1'b0;
    sprite_attr = 1'b0;
  endtask

  task automatic model_scan(input int line);
    sn = 0;
    sovf = 0;
    for (int i = 0; i < 32; i++) begin
      if (mv[i] == 1 && line >= my[i] && line - my[i] < 16) begin
        if (sn < 4) begin
          sx[sn] = mx[i];
          sp[sn] = mp[i];
          sr[sn] = line - my[i];
          sn++;
        end else begin
          sovf = 1;
        end
      end
    end
  endtask

  task automatic expect_ovf();
`ifdef SPRITE_OVERFLOW_EN
    check("overflow", 32'(spr_overflow), 32'(sovf));
`else
    check("overflow", 32'(spr_overflow), 32'd0);
`endif
  endtask

  // busy must span exactly 32 cycles and no hit is reported while scanning
  task automatic finish_scan(input int line);
    int busy;
    busy = 0;
    for (int i = 0; i < 32; i++) begin
      busy += int'(scan_busy);
      if (i > 0) check("hit_in_scan", 32'(spr_hit), 32'd0);
      tick();
    end
    check("busy_cycles", 32'(busy), 32'd32);
    check("busy_end", 32'(scan_busy), 32'd0);
    model_scan(line);
    expect_ovf();
  endtask

  task automatic run_scan(input int line, input int hpark);
    next_line  = 9'(line);
    h_count    = 10'(hpark);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    finish_scan(line);
  endtask

  task automatic sweep();
    int eh, ep, er, ec;
    for (int h = 0; h < 1024; h++) begin
      h_count = 10'(h);
      tick();
      eh = 0; ep = 0; er = 0; ec = 0;
      for (int k = 0; k < sn; k++) begin
        if (eh == 0 && h >= sx[k] && h < sx[k] + 16) begin
          eh = 1; ep = sp[k]; er = sr[k]; ec = h - sx[k];
        end
      end
      check($sformatf("hit@%0d", h), 32'(spr_hit), 32'(eh));
      if (eh == 1) begin
        check($sformatf("pattern@%0d", h), 32'(spr_pattern), 32'(ep));
        check($sformatf("row@%0d", h), 32'(spr_row), 32'(er));
        check($sformatf("col@%0d", h), 32'(spr_col), 32'(ec));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hit"}, 32'(spr_hit), 32'd0);
    check({tag, "_pattern"}, 32'(spr_pattern), 32'd0);
    check({tag, "_row"}, 32'(spr_row), 32'd0);
    check({tag, "_col"}, 32'(spr_col), 32'd0);
    check({tag, "_busy"}, 32'(scan_busy), 32'd0);
    check({tag, "_ovf"}, 32'(spr_overflow), 32'd0);
  endtask

  initial begin
    int line;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // empty table: nothing hits
    run_scan(100, 50);
    sweep();

    // single sprite with separate pos and attr writes
    write_spr(3, 1, 0, 50, 95, 0, 1);
    write_spr(3, 0, 1, 0, 0, 7, 1);
    run_scan(100, 50);
    sweep();

    // overlapping sprites: lower index wins
    write_spr(0, 1, 0, 200, 100, 0, 1);
    write_spr(0, 0, 1, 0, 0, 2, 1);
    write_spr(1, 1, 0, 200, 100, 0, 1);
    write_spr(1, 0, 1, 0, 0, 9, 1);
    run_scan(100, 200);
    sweep();

    // six sprites on one line: only four survive
    for (int i = 0; i < 32; i++) write_spr(i, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      write_spr(i, 1, 0, 20 + 100 * i, 10, 0, 1);
      write_spr(i, 0, 1, 0, 0, i + 1, 1);
    end
    run_scan(12, 0);
    sweep();

    // right-edge clipping
    for (int i = 0; i < 6; i++) write_spr(i, 1, 0, 0, 0, 0, 0);
    write_spr(7, 1, 0, 1015, 0, 0, 1);
    write_spr(7, 0, 1, 0, 0, 5, 1);
    run_scan(5, 0);
    sweep();

    // randomized table contents and lines, including combined writes
    for (int r = 0; r < 5; r++) begin
      line = int'($urandom_range(20, 480));
      for (int w = 0; w < 14; w++) begin
        int mode;
        mode = int'($urandom_range(0, 2));
        write_spr(int'($urandom_range(0, 31)), mode != 1, mode != 0,
                  int'($urandom_range(0, 1023)),
                  int'($urandom_range(line - 18, line + 3)),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0) ? 1 : 0);
      end
      run_scan(line, 0);
      sweep();
    end

    // restart at scan index 10
    next_line  = 9'(line + 7);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("busy_pre_restart", 32'(scan_busy), 32'd1);
      tick();
    end
    run_scan(line, 0);
    sweep();

    // reset in the middle of a scan
    next_line  = 9'(line);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (5) tick();
    check("busy_before_reset", 32'(scan_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    reset = 1'b0;
    clear_model();
    tick();
    sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_line_ctrl.md
# sprite_line_ctrl

Display-side endpoint for the sprite command strobes issued by the execute stage. Holds a 32-entry sprite attribute table written by those strobes. During each horizontal blank it scans the table for up to 4 sprites intersecting the next scanline. During the active line it reports per-pixel sprite hits (pattern, row, column) to the VGA pixel mux.

## Interface
Parameters:
- `NUM_SPR`, 32: sprite table entries; index width 5.
- `NUM_SLOTS`, 4: sprites per scanline.
- `SPR_SIZE`, 16: sprite width and height in pixels.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sprite_sel`  in  5  table index for the write.
- `sprite_x`  in  10  X position on a pos write; `[3:0]` is the pattern on an attr write.
- `sprite_y`  in  9  Y position on a pos write.
- `sprite_vis`  in  1  visible bit, written on both pos and attr writes.
- `sprite_pos`  in  1  one-cycle strobe: write x, y, vis.
- `sprite_attr`  in  1  one-cycle strobe: write pattern, vis.
- `line_start`  in  1  one-cycle strobe at the start of horizontal blank.
- `next_line`  in  9  scanline to be displayed after this blank.
- `h_count`  in  10  current pixel column.
- `spr_hit`  out  1  a sprite covers the pixel.
- `spr_pattern`  out  4  pattern index of the winning sprite.
- `spr_row`  out  4  row within the sprite.
- `spr_col`  out  4  column within the sprite.
- `scan_busy`  out  1  scan in progress.
- `spr_overflow`  out  1  more than `NUM_SLOTS` sprites matched the line.

## Operation
- Table entry fields: x[9:0], y[8:0], pattern[3:0], vis. Reset value of every entry is all zero, so every sprite is invisible.
- Write rules:
  - `sprite_pos` updates x, y and vis of entry `sprite_sel`.
  - `sprite_attr` updates pattern and vis.
  - Both strobes high in the same cycle: pos fields and pattern are written; vis = `sprite_vis`.
- Scan FSM:
  - States are IDLE, SCAN and DONE. Reset state is IDLE.
  - IDLE → SCAN on `line_start`. Latch `next_line`, clear all slot valid bits, clear the overflow count, set the index to 0.
  - SCAN: one entry per cycle, index 0..31. An entry matches when vis=1 and 0 ≤ (line − y) < 16, computed in 10-bit arithmetic with no wrap.
  - On a match, load the lowest free slot with x, pattern and row = (line − y)[3:0]. If all slots are full, set overflow.
  - After index 31, go to DONE. DONE → SCAN on `line_start`.
  - `line_start` during SCAN restarts the scan: slots are cleared and the index returns to 0.
- Pixel match: slot k hits when valid and x ≤ h_count < x+16, computed in 11 bits. A sprite at x ≥ 1009 is clipped and does not wrap. Column = (h_count − x)[3:0].
- Priority: the lowest slot wins, which is the lowest table index.
- Pixel outputs are driven only in DONE. In IDLE or SCAN, `spr_hit` = 0.
- Simultaneous table write and scan read of the same index: the scan sees the old value.

## Timing
- Reset values: all outputs 0, FSM IDLE, slots invalid.
- A table write is visible to the scan from the next cycle.
- A scan takes 32 cycles after `line_start`. `scan_busy` is high for exactly those 32 cycles.
- Horizontal blank must be at least 34 cycles.
- Pixel outputs are registered with 1-cycle latency from `h_count`.
- `spr_overflow` is updated during the scan, is valid in DONE, and holds until the next `line_start`.
- Reset asserted mid-scan returns the block to IDLE immediately and invalidates the slots.

## Configuration
- `SPRITE_OVERFLOW_EN` defined: overflow detection is compiled in, and `spr_overflow` behaves as above.
- Not defined: overflow logic is removed, `spr_overflow` is tied to 0, and surplus matches are silently dropped.

## Structure
- Shared `vga_defs` package holds:
  - `NUM_SPR`, `NUM_SLOTS`, `SPR_SIZE`;
  - the sprite entry struct (x, y, pattern, vis);
  - the scan-state enum (IDLE, SCAN, DONE).
- One sub-module, `sprite_slot_match`: per-slot register plus the x-range comparator. It is instantiated `NUM_SLOTS` times, and priority is resolved in the parent.

## Test plan
- Reset, then `line_start` with `next_line`=100 → `scan_busy` high for 32 cycles, then `spr_hit`=0 for every h_count.
- Sprite 3: pos x=50, y=95, vis=1; attr pattern=7. Scan line 100 → at h_count 50..65, `spr_hit`=1, pattern=7, row=5, col=0..15. `spr_hit`=0 at h_count 49 and 66.
- Sprites 0 and 1 both at x=200, y=100, patterns 2 and 9. Line 100 → at h_count 200, pattern=2 (sprite 0 wins).
- Six visible sprites all at y=10. Scan line 12 → sprites 0..3 displayed, sprites 4..5 dropped. `spr_overflow`=1 with the macro defined, 0 without.
- Sprite at x=1015 → hit at h_count 1015..1023 only, with no wrap to column 0.
- Second `line_start` at scan index 10 → scan restarts, `scan_busy` stays high for 32 more cycles. Reset mid-scan → all outputs 0 immediately.
